// File: rtl/hub75e_pkg.sv
// hub75e_pkg: shared defaults, pin bus layout, colour/state types and row-sequence helper.
package hub75e_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int SCAN_DEF = 32;
  localparam int ROW_W = 5;
  localparam int COL_W = 6;
  localparam int PIN_CLK = 6;
  localparam int PIN_LAT = 7;
  localparam int PIN_A = 9;
  localparam int PIN_W = 14;
  typedef logic [2:0] rgb3_t;
  typedef enum logic {RX_IDLE, RX_DRAIN} rx_state_e;
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] last);
    return r == last ? '0 : r + 1'b1;
  endfunction
endpackage

// File: rtl/hub75e_rx_if.sv
// hub75e_rx_if: per-pixel valid/ready stream carrying column, row and top/bottom colour.
interface hub75e_rx_if
  import hub75e_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic valid;
  logic ready;
  logic [$clog2(WIDTH)-1:0] x;
  logic [ROW_W-1:0] row;
  rgb3_t top;
  rgb3_t bot;
  logic last;
  modport master(output valid, x, row, top, bot, last, input ready);
  modport slave(input valid, x, row, top, bot, last, output ready);
endinterface

// File: rtl/hub75e_sync_edge.sv
// hub75e_sync_edge: multi-flop synchronizer with registered rising-edge detect and one-cycle-older tap.
module hub75e_sync_edge #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] cur,
  output logic [W-1:0] old,
  output logic [W-1:0] rise
);
  logic [STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0] dly_q, dly_d, old_q, old_d, rise_q, rise_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    dly_d = sync_q[STAGES-1];
    old_d = dly_q;
    rise_d = sync_q[STAGES-1] & ~dly_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      dly_q <= '0;
      old_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= sync_d;
      dly_q <= dly_d;
      old_q <= old_d;
      rise_q <= rise_d;
    end
  end
  // cur is aligned with rise; old holds the value from the cycle before the edge
  assign cur = dly_q;
  assign old = old_q;
  assign rise = rise_q;
endmodule

// File: rtl/hub75e_rx.sv
// hub75e_rx: HUB75E panel receiver that replays each latched line as a pixel stream.
// Define HUB75E_RX_STATS_EN to build frame_count and err_rowseq statistics.
module hub75e_rx
  import hub75e_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SCAN = SCAN_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        R1,
  input  logic        G1,
  input  logic        B1,
  input  logic        R2,
  input  logic        G2,
  input  logic        B2,
  input  logic        CLK,
  input  logic        LAT,
  input  logic        OE,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        E,
  hub75e_rx_if.master px,
  output logic        frame_start,
  output logic        err_len,
  output logic        err_overrun,
  output logic [15:0] frame_count,
  output logic        err_rowseq
);
  localparam int XW = $clog2(WIDTH);
  localparam logic [XW:0] FULL = (XW+1)'(WIDTH);
  localparam logic [XW-1:0] LAST = XW'(WIDTH-1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCAN-1);
  logic [PIN_W-1:0] pins, cur, old, rise;
  logic clk_rise, lat_rise, accept, valid, unused;
  logic [ROW_W-1:0] row_in;
  rx_state_e state_q, state_d;
  logic [XW:0] col_q, col_d, col_inc;
  logic ovf_q, ovf_d;
  logic [XW-1:0] x_q, x_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic frame_start_q, frame_start_d, err_len_q, err_len_d, err_overrun_q, err_overrun_d;
  logic [COL_W-1:0] shift_q [WIDTH];
  logic [COL_W-1:0] shift_d [WIDTH];
  logic [COL_W-1:0] line_q [WIDTH];
  logic [COL_W-1:0] line_d [WIDTH];
  assign pins = {E, D, C, B, A, OE, LAT, CLK, R1, G1, B1, R2, G2, B2};
  hub75e_sync_edge #(.W(PIN_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .din(pins), .cur(cur), .old(old), .rise(rise)
  );
  assign clk_rise = rise[PIN_CLK];
  assign lat_rise = rise[PIN_LAT];
  assign row_in = cur[PIN_A +: ROW_W];
  assign unused = ^{cur[PIN_A-1:0], old[PIN_W-1:COL_W], rise[PIN_W-1:PIN_LAT+1], rise[COL_W-1:0], LAST_ROW};
  // Column counter saturates at WIDTH; extra shifts only mark the line as overlong
  always_comb begin
    shift_d = shift_q;
    col_inc = col_q + {{XW{1'b0}}, clk_rise & ~col_q[XW]};
    if (clk_rise && !col_q[XW]) shift_d[col_q[XW-1:0]] = old[COL_W-1:0];
    col_d = lat_rise ? '0 : col_inc;
    ovf_d = !lat_rise && (ovf_q || (clk_rise && col_q[XW]));
  end
  always_comb begin
    accept = state_q == RX_IDLE && lat_rise;
    state_d = state_q;
    x_d = x_q;
    row_d = row_q;
    line_d = line_q;
    frame_start_d = accept && row_in == '0;
    err_len_d = err_len_q | (accept && (col_inc != FULL || ovf_q || (clk_rise && col_q[XW])));
    err_overrun_d = err_overrun_q | (state_q == RX_DRAIN && lat_rise);
    if (accept) begin
      state_d = RX_DRAIN;
      x_d = '0;
      row_d = row_in;
      line_d = shift_d;
    end else if (state_q == RX_DRAIN && px.ready) begin
      x_d = x_q + 1'b1;
      state_d = x_q == LAST ? RX_IDLE : RX_DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      col_q <= '0;
      ovf_q <= 1'b0;
      x_q <= '0;
      row_q <= '0;
      frame_start_q <= 1'b0;
      err_len_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      ovf_q <= ovf_d;
      x_q <= x_d;
      row_q <= row_d;
      frame_start_q <= frame_start_d;
      err_len_q <= err_len_d;
      err_overrun_q <= err_overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    line_q <= line_d;
  end
  assign valid = state_q == RX_DRAIN;
  assign px.valid = valid;
  assign px.x = x_q;
  assign px.row = row_q;
  assign px.top = valid ? line_q[x_q][5:3] : '0;
  assign px.bot = valid ? line_q[x_q][2:0] : '0;
  assign px.last = valid && x_q == LAST;
  assign frame_start = frame_start_q;
  assign err_len = err_len_q;
  assign err_overrun = err_overrun_q;
`ifdef HUB75E_RX_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [ROW_W-1:0] prev_row_q, prev_row_d;
  logic have_prev_q, have_prev_d, err_rowseq_q, err_rowseq_d;
  always_comb begin
    frame_count_d = frame_count_q + 16'(accept && row_in == '0);
    prev_row_d = accept ? row_in : prev_row_q;
    have_prev_d = have_prev_q | accept;
    err_rowseq_d = err_rowseq_q | (accept && have_prev_q && row_in != next_row(prev_row_q, LAST_ROW));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
      prev_row_q <= '0;
      have_prev_q <= 1'b0;
      err_rowseq_q <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      prev_row_q <= prev_row_d;
      have_prev_q <= have_prev_d;
      err_rowseq_q <= err_rowseq_d;
    end
  end
  assign frame_count = frame_count_q;
  assign err_rowseq = err_rowseq_q;
`else
  assign frame_count = '0;
  assign err_rowseq = 1'b0;
`endif
endmodule

// File: tb/tb_hub75e_rx.sv
// tb_hub75e_rx: directed vector table plus hand sequences for latency, overrun, reset and stats.
module tb_hub75e_rx;
  import hub75e_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic R1 = 0, G1 = 0, B1 = 0, R2 = 0, G2 = 0, B2 = 0;
  logic CLK = 0, LAT = 0, OE = 1, A = 0, B = 0, C = 0, D = 0, E = 0;
  logic frame_start, err_len, err_overrun, err_rowseq;
  logic [15:0] frame_count;
  hub75e_rx_if #(.WIDTH(64)) px();
  hub75e_rx #(.WIDTH(64), .SCAN(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
    .CLK(CLK), .LAT(LAT), .OE(OE), .A(A), .B(B), .C(C), .D(D), .E(E),
    .px(px),
    .frame_start(frame_start), .err_len(err_len), .err_overrun(err_overrun),
    .frame_count(frame_count), .err_rowseq(err_rowseq)
  );
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_beats = 0;
  int fs_cnt = 0;
  int mode = 0;
  logic [17:0] cap [4096];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pix(input int k, input bit inv);
    logic [2:0] t, b;
    if (k >= 64) return 6'b101101;
    t = 3'(k) ^ {3{inv}};
    b = ~3'(k) ^ {3{inv}};
    return {t, b};
  endfunction

  initial begin
    px.ready = 1'b1;
    forever begin
      @(negedge clk);
      px.ready = mode == 0 ? 1'b1 : mode == 1 ? ~px.ready : 1'b0;
    end
  end

  initial begin
    logic stall_prev;
    logic [18:0] held, now;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      now = {px.valid, px.x, px.row, px.top, px.bot, px.last};
      if (stall_prev && !reset) chk("stall_hold", 32'(now), 32'(held));
      if (px.valid && px.ready) begin
        cap[n_beats % 4096] = now[17:0];
        n_beats++;
      end
      stall_prev = px.valid && !px.ready && !reset;
      held = now;
      if (frame_start) fs_cnt++;
    end
  end

  task automatic pclk(input logic [5:0] p);
    {R1, G1, B1, R2, G2, B2} = p;
    repeat (3) @(negedge clk);
    CLK = 1'b1;
    repeat (3) @(negedge clk);
    CLK = 1'b0;
  endtask

  task automatic shift_line(input int n, input bit inv);
    for (int k = 0; k < n; k++) pclk(pix(k, inv));
  endtask

  task automatic do_latch(input logic [4:0] r);
    {E, D, C, B, A} = r;
    @(negedge clk);
    LAT = 1'b1;
    repeat (3) @(negedge clk);
    LAT = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input int b0, input string tag);
    int t;
    t = 0;
    while ((n_beats - b0 < 64 || px.valid) && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk($sformatf("%s_timeout", tag), 32'(t < 3000), 32'd1);
  endtask

  task automatic check_line(input int b0, input logic [4:0] r, input bit inv, input string tag);
    chk($sformatf("%s_beats", tag), n_beats - b0, 64);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(cap[(b0 + i) % 4096]), 32'({6'(i), r, pix(i, inv), i == 63}));
  endtask

  typedef struct {
    int nclk;
    logic [4:0] row;
    int rmode;
    bit exp_len;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int b0, hi, fs0, t;
    vecs[0] = '{64, 5'd5, 0, 1'b0};
    vecs[1] = '{64, 5'd6, 1, 1'b0};
    vecs[2] = '{70, 5'd9, 0, 1'b1};
    vecs[3] = '{63, 5'd10, 0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({px.valid, px.x, px.row, px.top, px.bot, px.last, frame_start, err_len, err_overrun}), 32'd0);
    chk("rst_stats", 32'({frame_count, err_rowseq}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      mode = vecs[v].rmode;
      b0 = n_beats;
      shift_line(vecs[v].nclk, 1'b0);
      do_latch(vecs[v].row);
      wait_done(b0, $sformatf("vec%0d", v));
      mode = 0;
      check_line(b0, vecs[v].row, 1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_err_len", v), 32'(err_len), 32'(vecs[v].exp_len));
      chk($sformatf("vec%0d_err_overrun", v), 32'(err_overrun), 32'd0);
    end

    b0 = n_beats;
    shift_line(64, 1'b0);
    {E, D, C, B, A} = 5'd12;
    @(negedge clk);
    LAT = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_valid_c%0d", k), 32'(px.valid), 32'(k == 4));
    end
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!px.valid) break;
      hi++;
    end
    chk("drain_len", hi, 64);
    @(negedge clk);
    LAT = 1'b0;
    repeat (3) @(negedge clk);
    check_line(b0, 5'd12, 1'b0, "lat");
    chk("lat_held_no_overrun", 32'(err_overrun), 32'd0);

    mode = 2;
    b0 = n_beats;
    shift_line(64, 1'b0);
    do_latch(5'd1);
    shift_line(64, 1'b1);
    do_latch(5'd2);
    chk("ovr_flag", 32'(err_overrun), 32'd1);
    chk("ovr_stalled", 32'({px.valid, px.x}), 32'({1'b1, 6'd0}));
    mode = 0;
    wait_done(b0, "ovr");
    check_line(b0, 5'd1, 1'b0, "ovr");
    repeat (100) @(negedge clk);
    chk("ovr_no_second_line", n_beats - b0, 64);

    b0 = n_beats;
    shift_line(64, 1'b1);
    do_latch(5'd3);
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      #2;
      if (n_beats - b0 >= 10) break;
    end
    chk("rst_reach_beat10", 32'(t < 200), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 32'(px.valid), 32'd0);
    chk("rst_mid_outputs", 32'({px.x, px.row, px.top, px.bot, px.last, frame_start, err_len, err_overrun}), 32'd0);
    chk("rst_mid_stats", 32'({frame_count, err_rowseq}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    b0 = n_beats;
    shift_line(64, 1'b0);
    do_latch(5'd4);
    wait_done(b0, "post_rst");
    check_line(b0, 5'd4, 1'b0, "post_rst");
    chk("post_rst_err_len", 32'(err_len), 32'd0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    fs0 = fs_cnt;
    for (int r = 0; r <= 32; r++) begin
      b0 = n_beats;
      do_latch(5'(r % 32));
      wait_done(b0, $sformatf("frame_row%0d", r));
    end
    chk("frame_start_pulses", fs_cnt - fs0, 2);
`ifdef HUB75E_RX_STATS_EN
    chk("frame_count", 32'(frame_count), 32'd2);
    chk("rowseq_clean", 32'(err_rowseq), 32'd0);
`else
    chk("frame_count_tied", 32'(frame_count), 32'd0);
    chk("rowseq_tied", 32'(err_rowseq), 32'd0);
`endif
    for (int r = 1; r <= 4; r++) begin
      b0 = n_beats;
      do_latch(r == 4 ? 5'd7 : 5'(r));
      wait_done(b0, $sformatf("seq_row%0d", r));
    end
`ifdef HUB75E_RX_STATS_EN
    chk("rowseq_jump", 32'(err_rowseq), 32'd1);
    chk("frame_count_after_jump", 32'(frame_count), 32'd2);
`else
    chk("rowseq_jump_tied", 32'(err_rowseq), 32'd0);
`endif
    chk("frame_err_len", 32'(err_len), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
